// File: rtl/usb_rx.sv
// USB full-speed receive front end and packet decoder.
//
// Oversamples the raw D+/D- pair, recovers bit timing from D+ transitions,
// NRZI-decodes and unstuffs the bit stream, then walks a packet through
// SYNC, PID, DATA and EOP. Data bytes (CRC included, unchecked) are pushed
// into the shared packet FIFO one byte at a time.
//
// Ports:
//   clk                  system clock
//   n_rst                asynchronous active-low reset
//   Dplus_in, Dminus_in  raw USB lines, asynchronous to clk
//   buffer_occupancy     current FIFO byte count (0..64)
//   rx_packet            PID nibble of the last good packet header
//   rx_packet_data       received data byte, LSB first on the wire
//   store_rx_packet_data one-cycle FIFO write strobe
//   rx_data_ready        one-cycle pulse on error-free end of packet
//   rx_transfer_active   high while a packet is being received
//   rx_error             sticky error flag, cleared by the next sync start

`timescale 1ns / 1ps

module usb_rx #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_PHASE = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       Dplus_in,
    input  logic       Dminus_in,
    input  logic [6:0] buffer_occupancy,
    output logic [3:0] rx_packet,
    output logic [7:0] rx_packet_data,
    output logic       store_rx_packet_data,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error
);

    localparam int unsigned PhW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPid,
        StData,
        StEop,
        StErr
    } state_e;

    // Line synchronizers and bit-timing recovery
    logic           dp_meta_q, dp_sync_q, dp_prev_q;
    logic           dm_meta_q, dm_sync_q;
    logic [PhW-1:0] phase_q;
    logic           resync;
    logic           sample;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta_q <= 1'b1;
            dp_sync_q <= 1'b1;
            dp_prev_q <= 1'b1;
            dm_meta_q <= 1'b0;
            dm_sync_q <= 1'b0;
            phase_q   <= '0;
        end else begin
            dp_meta_q <= Dplus_in;
            dp_sync_q <= dp_meta_q;
            dp_prev_q <= dp_sync_q;
            dm_meta_q <= Dminus_in;
            dm_sync_q <= dm_meta_q;
            if (resync || (phase_q == PhW'(CLKS_PER_BIT - 1))) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + PhW'(1);
            end
        end
    end

    assign resync = (dp_sync_q != dp_prev_q);
    // A D+ edge re-centres the bit window, so it suppresses a coincident sample.
    assign sample = !resync && (phase_q == PhW'(SAMPLE_PHASE));

    // Decode state
    state_e     state_q;
    logic       last_dp_q;
    logic [2:0] ones_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       eop_seen_q;
    logic [2:0] j_cnt_q;

    logic       se0, j_line, nrzi_bit;
    logic       in_packet, stuff_slot, stuff_err, bit_valid, byte_done;
    logic       se0_smp, sync_start, shift_en, pid_ok, enter_err;
    logic [7:0] shift_next;
    logic [2:0] ones_next;

    assign se0        = !dp_sync_q && !dm_sync_q;
    assign j_line     = dp_sync_q && !dm_sync_q;
    assign nrzi_bit   = (dp_sync_q == last_dp_q);
    assign in_packet  = (state_q == StSync) || (state_q == StPid) || (state_q == StData);
    assign stuff_slot = (ones_q == 3'd6);
    assign se0_smp    = sample && se0;
    assign stuff_err  = sample && !se0 && in_packet && stuff_slot && nrzi_bit;
    assign bit_valid  = sample && !se0 && in_packet && !stuff_slot;
    assign byte_done  = bit_valid && (bit_cnt_q == 3'd7);
    assign sync_start = (state_q == StIdle) && sample && !se0 && !nrzi_bit;
    assign shift_en   = bit_valid || sync_start;
    assign shift_next = {nrzi_bit, shift_q[7:1]};
    assign pid_ok     = (shift_next[3:0] == ~shift_next[7:4]);

    always_comb begin
        ones_next = 3'd0;
        if (!se0 && in_packet && !stuff_slot && nrzi_bit) begin
            ones_next = ones_q + 3'd1;
        end
    end

    always_comb begin
        enter_err = 1'b0;
        case (state_q)
            StSync:  enter_err = stuff_err || se0_smp || (byte_done && (shift_next != 8'h80));
            StPid:   enter_err = stuff_err || se0_smp || (byte_done && !pid_ok);
            StData:  enter_err = stuff_err || (se0_smp && (bit_cnt_q != 3'd0)) ||
                                 (byte_done && (buffer_occupancy >= 7'd64));
            StEop:   enter_err = sample && (eop_seen_q ? !j_line : !se0);
            default: enter_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q              <= StIdle;
            last_dp_q            <= 1'b1;
            ones_q               <= '0;
            shift_q              <= '0;
            bit_cnt_q            <= '0;
            eop_seen_q           <= 1'b0;
            j_cnt_q              <= '0;
            rx_packet            <= 4'h0;
            rx_packet_data       <= 8'h00;
            store_rx_packet_data <= 1'b0;
            rx_data_ready        <= 1'b0;
            rx_transfer_active   <= 1'b0;
            rx_error             <= 1'b0;
        end else begin
            store_rx_packet_data <= 1'b0;
            rx_data_ready        <= 1'b0;

            if (sample) begin
                last_dp_q <= dp_sync_q;
                ones_q    <= ones_next;
            end
            if (shift_en) begin
                shift_q   <= shift_next;
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            case (state_q)
                StIdle: begin
                    if (sync_start) begin
                        state_q            <= StSync;
                        rx_transfer_active <= 1'b1;
                        rx_error           <= 1'b0;
                    end
                end
                StSync: begin
                    if (byte_done) begin
                        state_q <= StPid;
                    end
                end
                StPid: begin
                    if (byte_done && pid_ok) begin
                        rx_packet <= shift_next[3:0];
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (se0_smp && (bit_cnt_q == 3'd0)) begin
                        state_q    <= StEop;
                        eop_seen_q <= 1'b0;
                    end else if (byte_done && (buffer_occupancy < 7'd64)) begin
                        rx_packet_data       <= shift_next;
                        store_rx_packet_data <= 1'b1;
                    end
                end
                StEop: begin
                    bit_cnt_q <= '0;
                    if (sample) begin
                        if (!eop_seen_q && se0) begin
                            eop_seen_q <= 1'b1;
                        end else if (eop_seen_q && j_line) begin
                            rx_data_ready      <= 1'b1;
                            rx_transfer_active <= 1'b0;
                            state_q            <= StIdle;
                        end
                    end
                end
                StErr: begin
                    bit_cnt_q <= '0;
                    if (sample) begin
                        if (j_line) begin
                            j_cnt_q <= j_cnt_q + 3'd1;
                            if (j_cnt_q == 3'd7) begin
                                state_q <= StIdle;
                            end
                        end else begin
                            j_cnt_q <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Error entry overrides any success transition decided above.
            if (enter_err) begin
                state_q            <= StErr;
                rx_error           <= 1'b1;
                rx_transfer_active <= 1'b0;
                j_cnt_q            <= '0;
            end
        end
    end

endmodule

// File: tb/tb_usb_rx.sv
// Self-checking bench for usb_rx: builds packets from bytes, applies bit
// stuffing and NRZI encoding, and compares decoded results with the bytes sent.

`timescale 1ns / 1ps

module tb_usb_rx;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       Dplus_in;
    logic       Dminus_in;
    logic [6:0] buffer_occupancy;
    logic [3:0] rx_packet;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet_data;
    logic       rx_data_ready;
    logic       rx_transfer_active;
    logic       rx_error;

    usb_rx #(
        .CLKS_PER_BIT(CPB),
        .SAMPLE_PHASE(3)
    ) dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .Dplus_in            (Dplus_in),
        .Dminus_in           (Dminus_in),
        .buffer_occupancy    (buffer_occupancy),
        .rx_packet           (rx_packet),
        .rx_packet_data      (rx_packet_data),
        .store_rx_packet_data(store_rx_packet_data),
        .rx_data_ready       (rx_data_ready),
        .rx_transfer_active  (rx_transfer_active),
        .rx_error            (rx_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Monitor: collect strobed bytes and ready pulses.
    logic [7:0] got_q[$];
    int         ready_cnt   = 0;
    int         overlap_cnt = 0;

    always @(negedge clk) begin
        if (store_rx_packet_data) got_q.push_back(rx_packet_data);
        if (rx_data_ready) ready_cnt++;
        if (store_rx_packet_data && rx_data_ready) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet builder: plain bits, stuffed and NRZI-encoded on the way out.
    bit   bq[$];
    int   ones_run;
    logic line_dp;

    task automatic drive_sym(input logic dp, input logic dm);
        Dplus_in  = dp;
        Dminus_in = dm;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_level(input bit b);
        if (!b) line_dp = !line_dp;
        drive_sym(line_dp, !line_dp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bq.push_back(b[i]);
    endtask

    task automatic push_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) bq.push_back(b[i]);
    endtask

    task automatic drive_bits();
        bit b;
        while (bq.size() > 0) begin
            b = bq.pop_front();
            send_level(b);
            if (b) begin
                ones_run++;
                if (ones_run == 6) begin
                    send_level(1'b0);
                    ones_run = 0;
                end
            end else begin
                ones_run = 0;
            end
        end
    endtask

    task automatic start_packet();
        ones_run = 0;
        line_dp  = 1'b1;
        push_byte(8'h80);
    endtask

    task automatic send_eop();
        drive_sym(1'b0, 1'b0);
        drive_sym(1'b0, 1'b0);
        drive_sym(1'b1, 1'b0);
        line_dp = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n) drive_sym(1'b1, 1'b0);
    endtask

    task automatic clear_mon();
        got_q.delete();
        ready_cnt = 0;
    endtask

    task automatic send_ack();
        start_packet();
        drive_bits();
        check("ack_active_mid", 32'(rx_transfer_active), 32'd1);
        push_byte(8'hD2);
        drive_bits();
        send_eop();
        idle_bits(4);
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] crc0, crc1, b;
    logic [3:0] pid;
    int         len;

    initial begin
        n_rst            = 1'b0;
        Dplus_in         = 1'b1;
        Dminus_in        = 1'b0;
        buffer_occupancy = 7'd0;
        line_dp          = 1'b1;
        ones_run         = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_packet", 32'(rx_packet), 32'h0);
        check("rst_rx_data", 32'(rx_packet_data), 32'h00);
        check("rst_store", 32'(store_rx_packet_data), 32'd0);
        check("rst_ready", 32'(rx_data_ready), 32'd0);
        check("rst_active", 32'(rx_transfer_active), 32'd0);
        check("rst_error", 32'(rx_error), 32'd0);
        n_rst = 1'b1;
        idle_bits(4);

        // ACK
        clear_mon();
        send_ack();
        check("ack_pid", 32'(rx_packet), 32'h2);
        check("ack_stores", 32'(got_q.size()), 32'd0);
        check("ack_ready", 32'(ready_cnt), 32'd1);
        check("ack_error", 32'(rx_error), 32'd0);
        check("ack_active_end", 32'(rx_transfer_active), 32'd0);

        // DATA0 with a stuffed 0xFF byte and two CRC bytes
        clear_mon();
        buffer_occupancy = 7'd5;
        crc0 = 8'($urandom);
        crc1 = 8'($urandom);
        start_packet();
        push_byte(8'hC3);
        push_byte(8'hFF);
        push_byte(8'h3F);
        push_byte(crc0);
        push_byte(crc1);
        drive_bits();
        send_eop();
        idle_bits(4);
        check("d0_pid", 32'(rx_packet), 32'h3);
        check("d0_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            check("d0_b0", 32'(got_q[0]), 32'hFF);
            check("d0_b1", 32'(got_q[1]), 32'h3F);
            check("d0_crc0", 32'(got_q[2]), 32'(crc0));
            check("d0_crc1", 32'(got_q[3]), 32'(crc1));
        end
        check("d0_ready", 32'(ready_cnt), 32'd1);
        check("d0_error", 32'(rx_error), 32'd0);

        // Bad PID
        clear_mon();
        start_packet();
        push_byte(8'hC7);
        drive_bits();
        send_eop();
        idle_bits(12);
        check("bad_pid_error", 32'(rx_error), 32'd1);
        check("bad_pid_keep", 32'(rx_packet), 32'h3);
        check("bad_pid_active", 32'(rx_transfer_active), 32'd0);
        check("bad_pid_ready", 32'(ready_cnt), 32'd0);
        clear_mon();
        send_ack();
        check("recover_error", 32'(rx_error), 32'd0);
        check("recover_pid", 32'(rx_packet), 32'h2);
        check("recover_ready", 32'(ready_cnt), 32'd1);

        // FIFO full during second data byte
        clear_mon();
        buffer_occupancy = 7'd10;
        start_packet();
        push_byte(8'hC3);
        push_byte(8'h12);
        drive_bits();
        buffer_occupancy = 7'd64;
        push_byte(8'h34);
        push_byte(8'h56);
        drive_bits();
        send_eop();
        idle_bits(12);
        buffer_occupancy = 7'd0;
        check("full_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) check("full_first", 32'(got_q[0]), 32'h12);
        check("full_error", 32'(rx_error), 32'd1);
        check("full_ready", 32'(ready_cnt), 32'd0);

        // SE0 after 5 bits of a data byte, then exactly 8 J bits before the next sync
        clear_mon();
        start_packet();
        push_byte(8'hC3);
        push_byte(8'h11);
        push_bits(8'h00, 5);
        drive_bits();
        drive_sym(1'b0, 1'b0);
        check("se0_error", 32'(rx_error), 32'd1);
        check("se0_active", 32'(rx_transfer_active), 32'd0);
        drive_sym(1'b0, 1'b0);
        line_dp = 1'b1;
        idle_bits(8);
        check("se0_count", 32'(got_q.size()), 32'd1);
        clear_mon();
        send_ack();
        check("se0_idle_ack_ready", 32'(ready_cnt), 32'd1);
        check("se0_idle_ack_error", 32'(rx_error), 32'd0);

        // Reset mid-DATA
        clear_mon();
        start_packet();
        push_byte(8'hC3);
        push_byte(8'hA5);
        push_bits(8'h0F, 4);
        drive_bits();
        check("rst_mid_stored", 32'(got_q.size()), 32'd1);
        n_rst     = 1'b0;
        Dplus_in  = 1'b1;
        Dminus_in = 1'b0;
        #1;
        check("rstm_rx_packet", 32'(rx_packet), 32'h0);
        check("rstm_rx_data", 32'(rx_packet_data), 32'h00);
        check("rstm_store", 32'(store_rx_packet_data), 32'd0);
        check("rstm_ready", 32'(rx_data_ready), 32'd0);
        check("rstm_active", 32'(rx_transfer_active), 32'd0);
        check("rstm_error", 32'(rx_error), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        idle_bits(10);
        clear_mon();
        send_ack();
        check("rstm_ack_pid", 32'(rx_packet), 32'h2);
        check("rstm_ack_ready", 32'(ready_cnt), 32'd1);
        check("rstm_ack_stores", 32'(got_q.size()), 32'd0);
        check("rstm_ack_error", 32'(rx_error), 32'd0);

        // Randomized data packets
        for (int k = 0; k < 6; k++) begin
            clear_mon();
            exp_q.delete();
            pid = ($urandom_range(0, 1) == 0) ? 4'h3 : 4'hB;
            len = int'($urandom_range(1, 4));
            buffer_occupancy = 7'($urandom_range(0, 63));
            start_packet();
            push_byte({~pid, pid});
            for (int i = 0; i < len; i++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                exp_q.push_back(b);
                push_byte(b);
            end
            drive_bits();
            send_eop();
            idle_bits(4);
            check("rand_pid", 32'(rx_packet), 32'(pid));
            check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i < got_q.size()) check("rand_byte", 32'(got_q[i]), 32'(exp_q[i]));
            end
            check("rand_ready", 32'(ready_cnt), 32'd1);
            check("rand_error", 32'(rx_error), 32'd0);
        end

        check("no_overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_rx.md
USB_RX -- requirements
Module: usb_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning clk cycles per USB bit time.
REQ-002 SHALL have parameter SAMPLE_PHASE, default 3, meaning the bit-phase count at which the line is sampled.
REQ-003 SHALL have port clk  in  1  system clock; the block uses this single clock.
REQ-004 SHALL have port n_rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port Dplus_in  in  1  raw USB D+ line, asynchronous to clk.
REQ-006 SHALL have port Dminus_in  in  1  raw USB D- line, asynchronous to clk.
REQ-007 SHALL have port buffer_occupancy  in  7  byte count of the shared packet FIFO, range 0..64.
REQ-008 SHALL have port rx_packet  out  4  PID nibble of the last valid received packet.
REQ-009 SHALL have port rx_packet_data  out  8  received data byte, LSB = first bit on the wire.
REQ-010 SHALL have port store_rx_packet_data  out  1  one-cycle FIFO write strobe for rx_packet_data.
REQ-011 SHALL have port rx_data_ready  out  1  one-cycle pulse: packet completed without error.
REQ-012 SHALL have port rx_transfer_active  out  1  high from sync detection until end of packet or error.
REQ-013 SHALL have port rx_error  out  1  sticky error flag.

Function
REQ-014 SHALL pass each of D+ and D- through a 2-flop synchronizer; reset values are D+=1 and D-=0 (J/idle).
REQ-015 SHALL run a phase counter 0..CLKS_PER_BIT-1 that wraps, and SHALL reset it to 0 on every cycle where synchronized D+ differs from its previous-cycle value (resync).
REQ-016 SHALL take a line sample when phase==SAMPLE_PHASE; SE0 = both synchronized lines low at the sample.
REQ-017 SHALL NRZI-decode each non-SE0 sample: bit=1 if D+ equals the previous sample's D+, else bit=0.
REQ-018 SHALL count consecutive decoded 1s; the bit following six 1s is a stuff bit and SHALL be discarded; a stuffed 1 there is a stuff error.
REQ-019 SHALL shift unstuffed bits LSB-first into an 8-bit register and count them with a 3-bit counter that wraps 7->0.
REQ-020 SHALL implement FSM states IDLE, SYNC, PID, DATA, EOP, ERR.
REQ-021 IDLE: on the first decoded 0 -> SYNC; rx_transfer_active SHALL rise 1 cycle after that sample.
REQ-022 SYNC: the 8 bits SHALL equal 8'h80 (seven 0s, then 1) -> PID; any mismatch -> ERR.
REQ-023 PID: after 8 bits, low nibble == ~high nibble -> latch rx_packet <= low nibble and go to DATA; otherwise -> ERR, and rx_packet is unchanged.
REQ-024 DATA: on each 8th bit, when buffer_occupancy<64, SHALL drive rx_packet_data and pulse store_rx_packet_data exactly 1 cycle after the completing sample; CRC bytes SHALL be stored and not checked.
REQ-025 DATA with buffer_occupancy==64 at byte completion: byte dropped, -> ERR.
REQ-026 SE0 sampled with bit count 0 in PID-complete/DATA -> EOP; SE0 with bit count !=0, or in SYNC/PID -> ERR.
REQ-027 EOP: SHALL require a second SE0 sample, then a J sample; on J, SHALL pulse rx_data_ready 1 cycle, drop rx_transfer_active, and go to IDLE; anything else -> ERR.
REQ-028 ERR: SHALL set rx_error and drop rx_transfer_active next cycle; SHALL stay in ERR until 8 consecutive J samples are seen, then go to IDLE.
REQ-029 Stuff error in any non-IDLE state SHALL go to ERR.
REQ-030 rx_error SHALL remain set until the next IDLE->SYNC transition, which clears it.
REQ-031 rx_data_ready and store_rx_packet_data SHALL never assert in the same cycle, and SHALL never assert in ERR.
REQ-032 Simultaneous resync edge and sample phase: the resync wins, and no sample is taken that cycle.

Reset
REQ-033 On n_rst low, all state SHALL clear immediately: FSM=IDLE, phase=0, counters=0, shift register=0.
REQ-034 Output reset values: rx_packet=4'h0, rx_packet_data=8'h00, store_rx_packet_data=0, rx_data_ready=0, rx_transfer_active=0, rx_error=0.
REQ-035 Reset asserted mid-packet SHALL abandon the packet with no strobe; after release, reception SHALL restart only at the next sync.

Verification
REQ-036 SHALL test ACK: sync + PID 8'hD2 + EOP -> rx_packet=4'h2, no store strobe, rx_data_ready pulses once, rx_error=0.
REQ-037 SHALL test DATA0: PID 8'hC3 + bytes 8'hFF, 8'h3F + 2 CRC bytes -> 4 store strobes with data FF, 3F, CRC0, CRC1, stuff bits removed, then rx_data_ready.
REQ-038 SHALL test a bad PID 8'hC7 -> rx_error=1, rx_packet retains its prior value, rx_transfer_active falls, and the next good packet clears rx_error.
REQ-039 SHALL test buffer_occupancy=64 during a data byte -> no strobe for that byte, rx_error=1, no rx_data_ready.
REQ-040 SHALL test SE0 after 5 bits of a data byte -> rx_error=1, and 8 J bit times later the FSM is back in IDLE.
REQ-041 SHALL test n_rst pulsed mid-DATA -> all outputs at reset values within the reset cycle, and a following ACK packet decodes correctly.
